aes_txn_ctrl: RTL and testbench
===============================

Name: aes_txn_ctrl

Overview:
- Transaction sequencer between the Tiny Tapeout pin-side byte host and the `aes` core byte bus.
- On `start`, streams IN_BYTES bytes (key then plaintext) from the host into the core under valid/ready.
- Collects OUT_BYTES result bytes into a small output FIFO, completes the core's ack handshake, and flags done or timeout error.

Parameters:
- IN_BYTES, 32, bytes forwarded host->core per transaction (1..255).
- OUT_BYTES, 16, bytes collected core->FIFO per transaction (1..255).
- FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.
- TIMEOUT, 1023, idle cycles without progress before abort (1..65535).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin transaction; sampled only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky timeout flag.
- src_id  out  2  module_source_id captured at ack.
- host_in_data  in  8  byte from host.
- host_in_valid  in  1  host byte valid.
- host_in_ready  out  1  controller accepts host byte.
- host_out_data  out  8  FIFO head byte.
- host_out_valid  out  1  FIFO not empty.
- host_out_ready  in  1  host pops FIFO head.
- aes_data_in  out  8  byte to core (`data_in`).
- aes_valid_in  out  1  to core `valid_in`.
- aes_ready_in  in  1  from core `ready_in`.
- aes_data_out  in  8  from core `data_out`.
- aes_data_valid  in  1  from core `data_valid`.
- aes_data_ready  out  1  to core `data_ready`.
- aes_ack_valid  in  1  from core `ack_valid`.
- aes_ack_ready  out  1  to core `ack_ready`.
- aes_source_id  in  2  from core `module_source_id`.

Behaviour:
- Reset (async assert, sync release): state=IDLE; byte_cnt=0; wdog=0; FIFO empty (wr/rd pointers and count = 0); src_id=0; err=0.
- Reset outputs: done=0, busy=0, host_in_ready=0, host_out_valid=0, aes_valid_in=0, aes_data_ready=0, aes_ack_ready=0, aes_data_in=host_in_data, host_out_data=X-free (mem[0] = 0 after reset).
- Handshake rule: transfer when valid & ready are both high on a rising edge. A valid, once raised, is never dropped by this block until the transfer occurs.

States:
- IDLE
  - start=1 -> LOAD; byte_cnt=0; wdog=0; err cleared.
  - start in any other state is ignored.
- LOAD: combinational pass-through.
  - aes_valid_in = host_in_valid; host_in_ready = aes_ready_in; aes_data_in = host_in_data.
  - Each transfer: byte_cnt++.
  - Transfer with byte_cnt = IN_BYTES-1 -> DRAIN; byte_cnt=0.
- DRAIN:
  - aes_data_ready = !fifo_full.
  - Each core transfer pushes aes_data_out into the FIFO; byte_cnt++.
  - Transfer with byte_cnt = OUT_BYTES-1 -> ACK.
- ACK:
  - aes_ack_ready = 1.
  - On aes_ack_valid: src_id <= aes_source_id; -> FLUSH.
- FLUSH: wait for FIFO empty; then done=1 for one cycle, -> IDLE (done asserts in the FLUSH->IDLE transition cycle).
- ERR:
  - err=1 (sticky until next accepted start); FIFO cleared; -> IDLE next cycle.
  - No done pulse.

Watchdog:
- Active in LOAD, DRAIN and ACK.
- Clears on any host-in, core-out or ack transfer, and on state entry; otherwise increments.
- wdog reaching TIMEOUT -> ERR.
- FLUSH is not timed; the host governs draining.

FIFO:
- host_out_valid = count != 0; pop on host_out_valid & host_out_ready, in any state.
- Full: push blocked via aes_data_ready=0. Pop while full frees one entry; the push is re-enabled the next cycle (aes_data_ready depends on registered count only).
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.

Other rules:
- aes_data_valid outside DRAIN is ignored (not pushed).
- aes_ack_valid outside ACK is ignored.
- Reset mid-transaction: immediate return to reset values; FIFO contents discarded.

Test Plan:
- Nominal: start; host sends 0x00..0x1F with valid held; core ready=1; core returns 0xA0..0xAF; host_out_ready=1; ack_valid with source_id=2'b10 -> 32 core input transfers in order, 16 bytes 0xA0..0xAF out in order, src_id=2, single done pulse, err=0.
- Backpressure: host_out_ready=0 during DRAIN, FIFO_DEPTH=4 -> exactly 4 bytes accepted then aes_data_ready=0. Release ready -> remaining 12 bytes arrive, no loss or duplication. done only after the 16th pop.
- Stall: core ready_in toggles 1/0 every cycle in LOAD -> host_in_ready mirrors it, byte_cnt reaches 32 with no lost bytes.
- Timeout: TIMEOUT=8; core never asserts data_valid in DRAIN -> ERR after 8 idle cycles, err=1, busy falls, FIFO empty. Next start clears err.
- Ignored events: start pulsed during LOAD, and ack_valid asserted during LOAD -> no state change, no src_id update.
- Async reset asserted mid-DRAIN with 3 bytes in the FIFO -> busy=0, host_out_valid=0, all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/aes_txn_ctrl_if.sv
// Byte-bus bundle between the transaction sequencer, the pin-side host and
// the aes core.
//   slave  : the controller's view (aes_txn_ctrl)
//   master : the environment's view (host pins + aes core)
// Signal groups:
//   control : start, busy, done, err, src_id
//   host in : host_in_data/valid/ready    (host -> controller)
//   host out: host_out_data/valid/ready   (FIFO head -> host)
//   core    : aes_data_in/valid_in/ready_in, aes_data_out/data_valid/data_ready,
//             aes_ack_valid/ack_ready, aes_source_id
interface aes_txn_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] src_id;

    logic [7:0] host_in_data;
    logic       host_in_valid;
    logic       host_in_ready;

    logic [7:0] host_out_data;
    logic       host_out_valid;
    logic       host_out_ready;

    logic [7:0] aes_data_in;
    logic       aes_valid_in;
    logic       aes_ready_in;
    logic [7:0] aes_data_out;
    logic       aes_data_valid;
    logic       aes_data_ready;
    logic       aes_ack_valid;
    logic       aes_ack_ready;
    logic [1:0] aes_source_id;

    modport slave (
        input  start, host_in_data, host_in_valid, host_out_ready,
               aes_ready_in, aes_data_out, aes_data_valid, aes_ack_valid, aes_source_id,
        output busy, done, err, src_id, host_in_ready, host_out_data, host_out_valid,
               aes_data_in, aes_valid_in, aes_data_ready, aes_ack_ready
    );

    modport master (
        output start, host_in_data, host_in_valid, host_out_ready,
               aes_ready_in, aes_data_out, aes_data_valid, aes_ack_valid, aes_source_id,
        input  busy, done, err, src_id, host_in_ready, host_out_data, host_out_valid,
               aes_data_in, aes_valid_in, aes_data_ready, aes_ack_ready
    );
endinterface

// File: rtl/aes_txn_ctrl.sv
// Transaction sequencer between the pin-side byte host and the aes core.
// On start it forwards IN_BYTES host bytes (key then plaintext) to the core,
// collects OUT_BYTES result bytes into a small FIFO the host drains, takes
// the core's ack (capturing its source id) and pulses done once the FIFO
// is empty. A watchdog aborts a stalled transaction into a sticky err.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : aes_txn_ctrl_if.slave (control, host in/out, core byte bus)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start
// S_LOAD  | host bytes pass straight through to the core
// S_DRAIN | core result bytes pushed into the output FIFO
// S_ACK   | waiting for the core ack, captures source id
// S_FLUSH | waiting for the host to empty the FIFO, then done
// S_ERR   | watchdog expired: set err, clear FIFO, back to idle
module aes_txn_ctrl #(
    parameter int IN_BYTES   = 32,
    parameter int OUT_BYTES  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input logic           clk,
    input logic           rst_n,
    aes_txn_ctrl_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0]       LP_IN_LAST   = 8'(IN_BYTES - 1);
    localparam logic [7:0]       LP_OUT_LAST  = 8'(OUT_BYTES - 1);
    localparam logic [15:0]      LP_WDOG_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_FULL      = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DRAIN, S_ACK, S_FLUSH, S_ERR
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_byte_cnt;
    logic [15:0]      r_wdog;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [1:0]       r_src_id;
    logic             r_err;

    logic w_full;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_ack_xfer;
    logic w_push;
    logic w_pop;
    logic w_timed;
    logic w_progress;
    logic w_expire;
    logic w_in_ready;
    logic w_valid_in;
    logic w_data_ready;
    logic w_ack_ready;
    logic w_done;

    // Full depends only on the registered count, so a pop while full
    // re-enables pushing one cycle later.
    assign w_full     = (r_count == LP_FULL);
    assign w_in_xfer  = (r_state == S_LOAD)  && bus.host_in_valid && bus.aes_ready_in;
    assign w_out_xfer = (r_state == S_DRAIN) && bus.aes_data_valid && !w_full;
    assign w_ack_xfer = (r_state == S_ACK)   && bus.aes_ack_valid;
    assign w_push     = w_out_xfer;
    assign w_pop      = (r_count != '0) && bus.host_out_ready;
    assign w_timed    = (r_state == S_LOAD) || (r_state == S_DRAIN) || (r_state == S_ACK);
    assign w_progress = w_in_xfer || w_out_xfer || w_ack_xfer;
    // r_wdog counts idle cycles already seen; this one makes TIMEOUT.
    assign w_expire   = w_timed && !w_progress && (r_wdog == LP_WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_in_ready   = 1'b0;
        w_valid_in   = 1'b0;
        w_data_ready = 1'b0;
        w_ack_ready  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_valid_in = bus.host_in_valid;
                w_in_ready = bus.aes_ready_in;
                if (w_in_xfer && (r_byte_cnt == LP_IN_LAST)) w_state_nxt = S_DRAIN;
                else if (w_expire)                           w_state_nxt = S_ERR;
            end
            S_DRAIN: begin
                w_data_ready = !w_full;
                if (w_out_xfer && (r_byte_cnt == LP_OUT_LAST)) w_state_nxt = S_ACK;
                else if (w_expire)                             w_state_nxt = S_ERR;
            end
            S_ACK: begin
                w_ack_ready = 1'b1;
                if (w_ack_xfer)    w_state_nxt = S_FLUSH;
                else if (w_expire) w_state_nxt = S_ERR;
            end
            S_FLUSH: begin
                if (r_count == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
            r_wdog     <= '0;
            r_src_id   <= '0;
            r_err      <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && bus.start) begin
                r_byte_cnt <= '0;
                r_err      <= 1'b0;
            end else if (w_in_xfer) begin
                r_byte_cnt <= (r_byte_cnt == LP_IN_LAST) ? 8'd0 : r_byte_cnt + 8'd1;
            end else if (w_out_xfer) begin
                r_byte_cnt <= r_byte_cnt + 8'd1;
            end

            // Any state change (including entry into a timed state) restarts it.
            if (w_timed && !w_progress && (w_state_nxt == r_state)) begin
                r_wdog <= r_wdog + 16'd1;
            end else begin
                r_wdog <= '0;
            end

            if (w_ack_xfer)        r_src_id <= bus.aes_source_id;
            if (r_state == S_ERR)  r_err    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (r_state == S_ERR) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= bus.aes_data_out;
        end
    end

    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = w_done;
    assign bus.err            = r_err;
    assign bus.src_id         = r_src_id;
    assign bus.host_in_ready  = w_in_ready;
    assign bus.host_out_data  = r_mem[r_rd_ptr];
    assign bus.host_out_valid = (r_count != '0);
    assign bus.aes_data_in    = bus.host_in_data;
    assign bus.aes_valid_in   = w_valid_in;
    assign bus.aes_data_ready = w_data_ready;
    assign bus.aes_ack_ready  = w_ack_ready;

endmodule

// File: tb/tb_aes_txn_ctrl.sv
module tb_aes_txn_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_txn_ctrl_if bus ();

    aes_txn_ctrl #(
        .IN_BYTES  (32),
        .OUT_BYTES (16),
        .FIFO_DEPTH(4),
        .TIMEOUT   (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Environment knobs (written by the stimulus block only).
    bit host_en  = 1'b0;
    int host_lim = 32;
    bit core_en  = 1'b0;
    int core_lim = 16;
    bit hout_rdy = 1'b0;
    int rdy_mode = 0;      // 0: ready_in=1, 1: toggle, 2: ready_in=0

    // Environment state (written by the env block only).
    int   host_idx = 0;
    int   core_idx = 0;
    logic rdy_r    = 1'b0;
    int   core_in_cnt  = 0;
    int   pop_cnt      = 0;
    int   done_cnt     = 0;
    int   pops_at_done = 0;

    logic [7:0] in_q[$];
    logic [7:0] out_q[$];

    assign bus.host_in_valid  = host_en && (host_idx < host_lim);
    assign bus.host_in_data   = 8'(host_idx);
    assign bus.aes_data_valid = core_en && (core_idx < core_lim);
    assign bus.aes_data_out   = 8'(32'hA0 + core_idx);
    assign bus.host_out_ready = hout_rdy;
    assign bus.aes_ready_in   = rdy_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit probe(input int sel);
        case (sel)
            0:       return bus.aes_ack_ready;
            1:       return !bus.busy;
            2:       return bus.busy && bus.host_out_valid && !bus.aes_data_ready;
            3:       return bus.aes_data_ready;
            4:       return bus.err;
            5:       return core_idx == 3;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input int lim);
        int n = 0;
        while (!probe(sel) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(probe(sel)), 32'd1);
    endtask

    // Sources, sinks and scoreboard monitor; handshakes sampled mid-cycle.
    always begin
        bit h_fire, c_fire, o_fire;
        @(negedge clk);
        h_fire = bus.host_in_valid && bus.host_in_ready;
        c_fire = bus.aes_data_valid && bus.aes_data_ready;
        o_fire = bus.host_out_valid && bus.host_out_ready;
        if (bus.aes_valid_in && bus.aes_ready_in) begin
            core_in_cnt++;
            if (in_q.size() == 0) chk("core_in_unexpected", 32'd1, 32'd0);
            else                  chk("core_in_byte", 32'(bus.aes_data_in), 32'(in_q.pop_front()));
        end
        if (o_fire) begin
            pop_cnt++;
            if (out_q.size() == 0) chk("host_out_unexpected", 32'd1, 32'd0);
            else                   chk("host_out_byte", 32'(bus.host_out_data), 32'(out_q.pop_front()));
        end
        if (bus.done) begin
            done_cnt++;
            pops_at_done = pop_cnt;
        end
        @(posedge clk);
        #1;
        if (!host_en)     host_idx = 0;
        else if (h_fire)  host_idx++;
        if (!core_en)     core_idx = 0;
        else if (c_fire)  core_idx++;
        rdy_r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ~rdy_r : 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic load_queues();
        for (int i = 0; i < 32; i++) in_q.push_back(8'(i));
        for (int i = 0; i < 16; i++) out_q.push_back(8'(8'hA0 + i));
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic do_ack(input logic [1:0] id);
        bus.aes_source_id = id;
        bus.aes_ack_valid = 1'b1;
        @(negedge clk);
        bus.aes_ack_valid = 1'b0;
    endtask

    initial begin
        int d0, p0, c0;
        rst_n             = 1'b0;
        bus.start         = 1'b0;
        bus.aes_ack_valid = 1'b0;
        bus.aes_source_id = 2'b00;
        #1;
        chk("rst_busy",       32'(bus.busy),           32'd0);
        chk("rst_done",       32'(bus.done),           32'd0);
        chk("rst_err",        32'(bus.err),            32'd0);
        chk("rst_src_id",     32'(bus.src_id),         32'd0);
        chk("rst_in_ready",   32'(bus.host_in_ready),  32'd0);
        chk("rst_out_valid",  32'(bus.host_out_valid), 32'd0);
        chk("rst_valid_in",   32'(bus.aes_valid_in),   32'd0);
        chk("rst_data_ready", 32'(bus.aes_data_ready), 32'd0);
        chk("rst_ack_ready",  32'(bus.aes_ack_ready),  32'd0);
        chk("rst_out_data",   32'(bus.host_out_data),  32'd0);
        chk("rst_data_in",    32'(bus.aes_data_in),    32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal transaction.
        d0 = done_cnt; p0 = pop_cnt; c0 = core_in_cnt;
        load_queues();
        rdy_mode = 0; hout_rdy = 1'b1; host_en = 1'b1; core_en = 1'b1;
        pulse_start();
        chk("nom_busy", 32'(bus.busy), 32'd1);
        wait_for("nom_reach_ack", 0, 200);
        do_ack(2'b10);
        wait_for("nom_idle", 1, 50);
        @(negedge clk);
        chk("nom_src_id",   32'(bus.src_id),    32'd2);
        chk("nom_err",      32'(bus.err),       32'd0);
        chk("nom_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("nom_core_in",  32'(core_in_cnt - c0), 32'd32);
        chk("nom_pops",     32'(pop_cnt - p0),  32'd16);
        chk("nom_in_q",     32'(in_q.size()),   32'd0);
        chk("nom_out_q",    32'(out_q.size()),  32'd0);
        host_en = 1'b0; core_en = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Stall on core ready_in plus ignored start/ack during LOAD.
        d0 = done_cnt; c0 = core_in_cnt;
        load_queues();
        rdy_mode = 1; host_en = 1'b1; core_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("stall_mirror", 32'(bus.host_in_ready), 32'(bus.aes_ready_in));
            chk("stall_valid",  32'(bus.aes_valid_in),  32'(bus.host_in_valid));
            @(negedge clk);
        end
        bus.start = 1'b1;
        bus.aes_source_id = 2'b01;
        bus.aes_ack_valid = 1'b1;
        @(negedge clk);
        chk("ign_busy",      32'(bus.busy),          32'd1);
        chk("ign_ack_ready", 32'(bus.aes_ack_ready), 32'd0);
        bus.start = 1'b0;
        bus.aes_ack_valid = 1'b0;
        @(negedge clk);
        chk("ign_src_id",  32'(bus.src_id), 32'd2);
        chk("ign_in_load", 32'(bus.host_in_ready), 32'(bus.aes_ready_in));
        wait_for("stall_reach_ack", 0, 300);
        chk("stall_core_in", 32'(core_in_cnt - c0), 32'd32);
        do_ack(2'b11);
        wait_for("stall_idle", 1, 50);
        @(negedge clk);
        chk("stall_src_id",   32'(bus.src_id),       32'd3);
        chk("stall_done_cnt", 32'(done_cnt - d0),    32'd1);
        chk("stall_out_q",    32'(out_q.size()),     32'd0);
        rdy_mode = 0; host_en = 1'b0; core_en = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // FIFO backpressure.
        d0 = done_cnt; p0 = pop_cnt;
        load_queues();
        hout_rdy = 1'b0; host_en = 1'b1; core_en = 1'b1;
        pulse_start();
        wait_for("bp_full", 2, 100);
        chk("bp_accepted", 32'(core_idx), 32'd4);
        @(negedge clk);
        @(negedge clk);
        chk("bp_still_blocked", 32'(bus.aes_data_ready), 32'd0);
        chk("bp_still_4",       32'(core_idx),           32'd4);
        hout_rdy = 1'b1;
        wait_for("bp_reach_ack", 0, 100);
        do_ack(2'b01);
        wait_for("bp_idle", 1, 50);
        @(negedge clk);
        chk("bp_pops",         32'(pop_cnt - p0),  32'd16);
        chk("bp_pops_at_done", 32'(pops_at_done - p0), 32'd16);
        chk("bp_done_cnt",     32'(done_cnt - d0), 32'd1);
        chk("bp_out_q",        32'(out_q.size()),  32'd0);
        chk("bp_src_id",       32'(bus.src_id),    32'd1);
        host_en = 1'b0; core_en = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Watchdog timeout in DRAIN (core never offers data).
        d0 = done_cnt;
        for (int i = 0; i < 32; i++) in_q.push_back(8'(i));
        host_en = 1'b1;
        pulse_start();
        wait_for("to_reach_drain", 3, 100);
        for (int i = 0; i < 6; i++) @(negedge clk);
        chk("to_not_yet", 32'(bus.err), 32'd0);
        wait_for("to_err", 4, 10);
        chk("to_busy",      32'(bus.busy),           32'd0);
        chk("to_out_valid", 32'(bus.host_out_valid), 32'd0);
        chk("to_no_done",   32'(done_cnt - d0),      32'd0);
        @(negedge clk);
        chk("to_err_sticky", 32'(bus.err), 32'd1);
        host_en = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Next start clears err; then async reset mid-DRAIN with 3 bytes held.
        for (int i = 0; i < 32; i++) in_q.push_back(8'(i));
        host_en = 1'b1; core_en = 1'b1; core_lim = 3; hout_rdy = 1'b0;
        pulse_start();
        chk("restart_err",  32'(bus.err),  32'd0);
        chk("restart_busy", 32'(bus.busy), 32'd1);
        wait_for("rst_mid_fill", 5, 100);
        chk("rst_mid_valid_pre", 32'(bus.host_out_valid), 32'd1);
        chk("rst_mid_in_q",      32'(in_q.size()),        32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",       32'(bus.busy),           32'd0);
        chk("arst_out_valid",  32'(bus.host_out_valid), 32'd0);
        chk("arst_data_ready", 32'(bus.aes_data_ready), 32'd0);
        chk("arst_out_data",   32'(bus.host_out_data),  32'd0);
        chk("arst_src_id",     32'(bus.src_id),         32'd0);
        chk("arst_err",        32'(bus.err),            32'd0);
        host_en = 1'b0; core_en = 1'b0; core_lim = 16;
        in_q.delete();
        out_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
